// File: rtl/snn_soc_pkg.sv
// Shared types for the bus sequencer: command word, opcodes, error codes, FSM states.
package snn_soc_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_WR    = 3'd1,
    OP_RD    = 3'd2,
    OP_POLL1 = 3'd3,
    OP_POLL0 = 3'd4,
    OP_END   = 3'd5
  } seq_op_e;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
  } seq_cmd_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_BUS   = 2'd1;
  localparam logic [1:0] ERR_POLL  = 2'd2;
  localparam logic [1:0] ERR_ABORT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ACCESS,
    ST_CHECK,
    ST_FIN
  } seq_state_e;

  // POLL1 waits for any masked bit set, POLL0 for all masked bits clear.
  function automatic logic poll_hit(logic [2:0] op, logic [31:0] rd, logic [31:0] mask);
    logic any;
    any = |(rd & mask);
    return (op == OP_POLL1) ? any : !any;
  endfunction

endpackage

// File: rtl/seq_cmd_ram.sv
// Command table: one write port, one registered read port; contents are not reset.
module seq_cmd_ram
  import snn_soc_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  seq_cmd_t      wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output seq_cmd_t      rdata
);

  seq_cmd_t mem_q [DEPTH];
  seq_cmd_t rdata_q;

  // Read data is held while re is low, so it doubles as the current-command register.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= (we && waddr == raddr) ? wdata : mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bus_seq_master.sv
// Table-driven bus master: runs WR/RD/POLL commands from seq_cmd_ram until END or the last entry.
module bus_seq_master
  import snn_soc_pkg::*;
#(
  parameter  int CMD_DEPTH = 16,
  parameter  int POLL_MAX  = 1024,
  parameter  int BUS_TMO   = 64,
  localparam int AW        = $clog2(CMD_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_idx,
  input  seq_cmd_t      cfg_cmd,
  output logic          m_valid,
  output logic          m_write,
  output logic [31:0]   m_addr,
  output logic [31:0]   m_wdata,
  output logic [3:0]    m_wstrb,
  input  logic          m_ready,
  input  logic          m_rvalid,
  input  logic [31:0]   m_rdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [AW-1:0] err_idx,
  output logic [31:0]   last_rdata
);

  localparam int PW = $clog2(POLL_MAX) + 1;
  localparam int TW = $clog2(BUS_TMO) + 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(BUS_TMO - 1);
  localparam logic [AW-1:0] PC_LAST   = AW'(CMD_DEPTH - 1);

  seq_state_e    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          done_q, done_d, err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic [AW-1:0] eidx_q, eidx_d;
  logic [31:0]   last_q, last_d;

  logic          ram_re;
  logic [AW-1:0] ram_raddr;
  seq_cmd_t      cmd;
  logic [AW-1:0] pc_inc;
  logic          is_wr, cmpl;

  seq_cmd_ram #(.DEPTH(CMD_DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (cfg_we && state_q == ST_IDLE),
    .waddr (cfg_idx),
    .wdata (cfg_cmd),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (cmd)
  );

  assign pc_inc = pc_q + 1'b1;
  assign is_wr  = (cmd.op == OP_WR);
  assign cmpl   = is_wr ? m_ready : m_rvalid;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    poll_d    = poll_q;
    tmr_d     = tmr_q;
    done_d    = done_q;
    err_d     = err_q;
    code_d    = code_q;
    eidx_d    = eidx_q;
    last_d    = last_q;
    ram_re    = 1'b0;
    ram_raddr = pc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_FETCH;
          pc_d      = '0;
          done_d    = 1'b0;
          err_d     = 1'b0;
          code_d    = ERR_NONE;
          eidx_d    = '0;
          ram_re    = 1'b1;
          ram_raddr = '0;
        end
      end
      ST_FETCH: begin
        poll_d = '0;
        case (cmd.op)
          OP_END: begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end
          OP_WR, OP_RD, OP_POLL1, OP_POLL0: begin
            state_d = ST_ACCESS;
            tmr_d   = '0;
          end
          default: begin
            // NOP on the last entry behaves like the implicit END
            if (pc_q == PC_LAST) begin
              state_d = ST_FIN;
              done_d  = 1'b1;
            end else begin
              pc_d      = pc_inc;
              ram_re    = 1'b1;
              ram_raddr = pc_inc;
            end
          end
        endcase
      end
      ST_ACCESS: begin
        if (cmpl) begin
          state_d = ST_CHECK;
          if (!is_wr) last_d = m_rdata;
        end else if (tmr_q == TMO_LAST) begin
          state_d = ST_FIN;
          err_d   = 1'b1;
          code_d  = ERR_BUS;
          eidx_d  = pc_q;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_CHECK: begin
        if (is_wr || cmd.op == OP_RD || poll_hit(cmd.op, last_q, cmd.data)) begin
          if (pc_q == PC_LAST) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_FETCH;
            pc_d      = pc_inc;
            ram_re    = 1'b1;
            ram_raddr = pc_inc;
          end
        end else if (poll_q < POLL_LAST) begin
          state_d = ST_ACCESS;
          poll_d  = poll_q + 1'b1;
          tmr_d   = '0;
        end else begin
          state_d = ST_FIN;
          err_d   = 1'b1;
          code_d  = ERR_POLL;
          eidx_d  = pc_q;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides anything decided above, including a same-cycle completion.
    if (abort && (state_q == ST_FETCH || state_q == ST_ACCESS || state_q == ST_CHECK)) begin
      state_d = ST_FIN;
      done_d  = 1'b0;
      err_d   = 1'b1;
      code_d  = ERR_ABORT;
      eidx_d  = pc_q;
      last_d  = last_q;
      ram_re  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      poll_q  <= '0;
      tmr_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      eidx_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      poll_q  <= poll_d;
      tmr_q   <= tmr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      eidx_q  <= eidx_d;
      last_q  <= last_d;
    end
  end

  // Bus outputs decode straight from the state, so reset drops m_valid immediately.
  assign m_valid    = (state_q == ST_ACCESS);
  assign m_write    = m_valid && is_wr;
  assign m_addr     = m_valid ? cmd.addr : 32'h0;
  assign m_wdata    = m_write ? cmd.data : 32'h0;
  assign m_wstrb    = m_write ? 4'hF : 4'h0;
  assign busy       = (state_q == ST_FETCH) || (state_q == ST_ACCESS) || (state_q == ST_CHECK);
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = code_q;
  assign err_idx    = eidx_q;
  assign last_rdata = last_q;

endmodule

// File: tb/tb_bus_seq_master.sv
// Directed bench for bus_seq_master: slave model, transaction-level reference model, per-cycle monitor.
module tb_bus_seq_master;
  import snn_soc_pkg::*;

  localparam int D   = 4;
  localparam int PM  = 8;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst, start, abort, cfg_we;
  logic [1:0]  cfg_idx;
  seq_cmd_t    cfg_cmd;
  logic        m_valid, m_write, m_ready, m_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata, last_rdata;
  logic [3:0]  m_wstrb;
  logic        busy, done, err;
  logic [1:0]  err_code, err_idx;

  always #5 clk = ~clk;

  bus_seq_master #(.CMD_DEPTH(D), .POLL_MAX(PM), .BUS_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_cmd(cfg_cmd),
    .m_valid(m_valid), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .err_idx(err_idx),
    .last_rdata(last_rdata)
  );

  int checks = 0, failures = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference state
  seq_cmd_t    tab [D];
  logic [31:0] exp_a[$], exp_d[$], rdq[$];
  bit          exp_w[$];
  logic [31:0] rd_default = 32'h0;
  int          lat = 1;
  bit          respond = 1'b1;
  bit          mdl_done, mdl_err;
  logic [1:0]  mdl_code, mdl_idx;
  logic [31:0] mdl_last = 32'h0;

  // Monitor statistics
  int          acc_cnt, rd_cnt, run_len, max_run;
  logic [31:0] obs_a[$];

  // Walks the table as a program, consuming slave read data in order.
  task automatic model_run();
    logic [31:0] q[$];
    logic [31:0] rd;
    logic [2:0]  op;
    int          pc, tries;
    bit          fin, adv;
    q = rdq; pc = 0; fin = 0;
    mdl_done = 0; mdl_err = 0; mdl_code = 0; mdl_idx = 0;
    while (!fin) begin
      op = tab[pc].op; adv = 0;
      if (op >= 3'd1 && op <= 3'd4) begin
        tries = (op >= 3'd3) ? PM : 1;
        for (int n = 0; n < tries && !adv && !fin; n++) begin
          exp_a.push_back(tab[pc].addr);
          exp_w.push_back(op == 3'd1);
          exp_d.push_back(op == 3'd1 ? tab[pc].data : 32'h0);
          if (!respond) begin
            mdl_err = 1; mdl_code = 2'd1; mdl_idx = 2'(pc); fin = 1;
          end else if (op == 3'd1) begin
            adv = 1;
          end else begin
            rd = (q.size() != 0) ? q.pop_front() : rd_default;
            mdl_last = rd;
            if (op == 3'd2 || (op == 3'd3 && (rd & tab[pc].data) != 0) ||
                (op == 3'd4 && (rd & tab[pc].data) == 0)) adv = 1;
          end
        end
        if (!fin && !adv) begin
          mdl_err = 1; mdl_code = 2'd2; mdl_idx = 2'(pc); fin = 1;
        end
      end else if (op == 3'd5) begin
        mdl_done = 1; fin = 1;
      end else begin
        adv = 1;
      end
      if (adv) begin
        if (pc == D - 1) begin mdl_done = 1; fin = 1; end
        else pc++;
      end
    end
  endtask

  // Slave: answers lat cycles into each access, one-cycle response.
  initial begin
    int scnt;
    scnt = 0; m_ready = 0; m_rvalid = 0; m_rdata = 0;
    forever begin
      @(negedge clk);
      m_ready = 0; m_rvalid = 0;
      if (rst || !m_valid) scnt = 0;
      else begin
        scnt++;
        if (respond && scnt == lat) begin
          if (m_write) m_ready = 1;
          else begin
            m_rvalid = 1;
            m_rdata  = (rdq.size() != 0) ? rdq.pop_front() : rd_default;
          end
        end
      end
    end
  end

  // Monitor: each access against the model's list, stability while pending, exclusivity of done/err.
  initial begin
    bit          pv;
    logic [31:0] ha, hd;
    logic        hw;
    pv = 0; ha = 0; hd = 0; hw = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0; run_len = 0;
      end else begin
        chk("done_err_excl", {63'h0, done && err}, 64'h0);
        if (m_valid && !pv) begin
          acc_cnt++;
          if (!m_write) rd_cnt++;
          obs_a.push_back(m_addr);
          if (exp_a.size() == 0) begin
            checks++; failures++;
            $display("FAIL extra_access: got addr %0h expected none", m_addr);
          end else begin
            ha = exp_a.pop_front(); hw = exp_w.pop_front(); hd = exp_d.pop_front();
            chk("acc_addr", m_addr, ha);
            chk("acc_write", m_write, hw);
            chk("acc_wdata", m_wdata, hd);
            chk("acc_wstrb", m_wstrb, hw ? 4'hF : 4'h0);
          end
          ha = m_addr; hw = m_write; hd = m_wdata;
        end else if (m_valid) begin
          chk("hold_stable", {m_addr, m_wdata}, {ha, hd});
        end
        if (m_valid) run_len++;
        else begin
          if (run_len > max_run) max_run = run_len;
          run_len = 0;
        end
        pv = m_valid;
      end
    end
  end

  task automatic load(int i, logic [2:0] op, logic [31:0] a, logic [31:0] d);
    @(negedge clk);
    cfg_we = 1; cfg_idx = 2'(i); cfg_cmd = '{op: op, addr: a, data: d};
    tab[i] = '{op: op, addr: a, data: d};
    @(negedge clk);
    cfg_we = 0;
  endtask

  task automatic kick();
    acc_cnt = 0; rd_cnt = 0; max_run = 0; obs_a.delete();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    chk("busy_after_start", busy, 1);
    chk("done_clr", done, 0);
    chk("err_clr", err, 0);
  endtask

  task automatic run(string tag);
    model_run();
    kick();
    for (int c = 0; c < 3000 && busy; c++) @(negedge clk);
    if (busy) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got busy=1 expected busy=0", tag);
    end
    @(negedge clk);
    chk({tag, "_done"}, done, mdl_done);
    chk({tag, "_err"}, err, mdl_err);
    chk({tag, "_code"}, err_code, mdl_code);
    chk({tag, "_idx"}, err_idx, mdl_idx);
    chk({tag, "_last"}, last_rdata, mdl_last);
    chk({tag, "_leftover"}, exp_a.size(), 0);
    exp_a.delete(); exp_w.delete(); exp_d.delete();
  endtask

  task automatic wait_valid(string tag);
    int c;
    for (c = 0; c < 50 && !m_valid; c++) @(negedge clk);
    if (!m_valid) begin
      checks++; failures++;
      $display("FAIL %s_novalid: got m_valid=0 expected 1", tag);
    end
  endtask

  initial begin
    rst = 1; start = 0; abort = 0; cfg_we = 0; cfg_idx = 0; cfg_cmd = '0;
    repeat (3) @(negedge clk);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {done, err, err_code, err_idx}, 0);
    chk("rst_bus", {m_addr, m_wdata, m_wstrb, m_write}, 0);
    chk("rst_last", last_rdata, 0);
    rst = 0;

    // Two writes then END, slave ready after 2 cycles
    load(0, 3'd1, 32'h1000_0004, 32'd10);
    load(1, 3'd1, 32'h1000_0000, 32'h0001_0200);
    load(2, 3'd5, 32'h0, 32'h0);
    load(3, 3'd0, 32'h0, 32'h0);
    lat = 2; respond = 1;
    run("wr2");
    chk("wr2_cnt", acc_cnt, 2);
    chk("wr2_a0", obs_a[0], 32'h1000_0004);
    chk("wr2_a1", obs_a[1], 32'h1000_0000);
    chk("wr2_hold", max_run, 2);
    chk("wr2_done", {done, err}, 2'b10);

    // POLL1 satisfied on the fourth read
    load(0, 3'd3, 32'h2000_0010, 32'h2);
    load(1, 3'd5, 32'h0, 32'h0);
    lat = 1; rdq = '{32'h0, 32'h0, 32'h0, 32'h2};
    run("poll1");
    chk("poll1_reads", rd_cnt, 4);
    chk("poll1_last", last_rdata, 32'h2);
    chk("poll1_done", done, 1);

    // POLL0 never satisfied: poll timeout on entry 1
    load(0, 3'd1, 32'h0000_0004, 32'h1);
    load(1, 3'd4, 32'h2000_0020, 32'h80);
    load(2, 3'd5, 32'h0, 32'h0);
    rdq.delete(); rd_default = 32'h80;
    run("poll0");
    chk("poll0_reads", rd_cnt, PM);
    chk("poll0_err", {err, err_code, err_idx}, {1'b1, 2'd2, 2'd1});

    // Slave silent: bus timeout on entry 1 after a NOP
    load(0, 3'd0, 32'h0, 32'h0);
    load(1, 3'd1, 32'h5000_0000, 32'hDEAD_BEEF);
    load(2, 3'd5, 32'h0, 32'h0);
    respond = 0;
    run("tmo");
    chk("tmo_len", max_run, TMO);
    chk("tmo_err", {err, err_code, err_idx}, {1'b1, 2'd1, 2'd1});

    // Abort during a POLL access
    load(0, 3'd3, 32'h3000_0000, 32'h1);
    load(1, 3'd5, 32'h0, 32'h0);
    exp_a.push_back(32'h3000_0000); exp_w.push_back(1'b0); exp_d.push_back(32'h0);
    kick();
    wait_valid("abort");
    repeat (3) @(negedge clk);
    abort = 1;
    @(negedge clk); abort = 0;
    chk("abort_mvalid", m_valid, 0);
    chk("abort_err", {done, err, err_code, err_idx}, {1'b0, 1'b1, 2'd3, 2'd0});
    @(negedge clk);

    // Restart from entry 0: reads with an undefined opcode (NOP) in between
    load(0, 3'd2, 32'h6000_0000, 32'h0);
    load(1, 3'd7, 32'h6000_00F0, 32'h0);
    load(2, 3'd2, 32'h6000_0004, 32'h0);
    load(3, 3'd5, 32'h0, 32'h0);
    respond = 1; lat = 2; rd_default = 32'h0;
    rdq = '{32'h1234_5678, 32'hCAFE_0001};
    run("rd");
    chk("rd_reads", rd_cnt, 2);
    chk("rd_last", last_rdata, 32'hCAFE_0001);
    chk("rd_done", {done, err}, 2'b10);

    // Full table without END: implicit END after the last entry
    for (int i = 0; i < D; i++) load(i, 3'd1, 32'h7000_0000 + 32'(4 * i), 32'(i + 1));
    lat = 3;
    run("full");
    chk("full_cnt", acc_cnt, D);
    chk("full_done", done, 1);
    repeat (20) @(negedge clk);
    chk("full_no_more", acc_cnt, D);

    // Reset mid-access drops m_valid without a clock edge
    load(0, 3'd1, 32'h8000_0000, 32'h5);
    load(1, 3'd5, 32'h0, 32'h0);
    respond = 0;
    exp_a.push_back(32'h8000_0000); exp_w.push_back(1'b1); exp_d.push_back(32'h5);
    kick();
    wait_valid("rstmid");
    @(negedge clk);
    #1 rst = 1;
    #1 chk("rstmid_mvalid", m_valid, 0);
    chk("rstmid_flags", {busy, done, err}, 0);
    @(negedge clk); rst = 0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_seq_master.md
BUS_SEQ_MASTER -- requirements
Module: bus_seq_master

Interface
REQ-001 Parameter CMD_DEPTH, default 16, number of command-table entries (power of 2, >=2).
REQ-002 Parameter POLL_MAX, default 1024, maximum reads per POLL command before poll-timeout error.
REQ-003 Parameter BUS_TMO, default 64, maximum cycles m_valid may stay high without completion before bus-timeout error.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to run the table from entry 0.
REQ-007 abort  in  1  stop the running sequence immediately.
REQ-008 cfg_we  in  1  write one command-table entry.
REQ-009 cfg_idx  in  $clog2(CMD_DEPTH)  entry index for cfg_we.
REQ-010 cfg_cmd  in  seq_cmd_t  command: op[2:0], addr[31:0], data[31:0].
REQ-011 m_valid, m_write  out  1 each  bus request and direction.
REQ-012 m_addr, m_wdata  out  32 each; m_wstrb  out  4.
REQ-013 m_ready  in  1  write accepted; m_rvalid  in  1  read data valid; m_rdata  in  32.
REQ-014 busy  out  1  sequence running.
REQ-015 done  out  1  sticky, sequence finished without error.
REQ-016 err  out  1  sticky, sequence stopped on error; err_code  out  2; err_idx  out  $clog2(CMD_DEPTH).
REQ-017 last_rdata  out  32  data of most recent completed read.

Function
REQ-018 Ops: NOP=0, WR=1, RD=2, POLL1=3 (until rdata&data != 0), POLL0=4 (until rdata&data == 0), END=5; codes 6-7 treated as NOP.
REQ-019 States: IDLE, FETCH, ACCESS, CHECK, FIN; FIN returns to IDLE after one cycle with busy low.
REQ-020 start sampled in IDLE: next cycle FETCH, pc=0, done/err/err_code/err_idx cleared, busy=1.
REQ-021 start while busy ignored; cfg_we while busy ignored; cfg_we in IDLE updates the entry on the same edge.
REQ-022 FETCH: register table[pc] into current command (1 cycle); NOP -> pc+1, END -> FIN with done=1; else ACCESS.
REQ-023 ACCESS: m_valid=1, m_addr=cmd.addr, m_write=(op==WR), m_wdata=cmd.data for WR else 0, m_wstrb=4'hF for WR else 0; all held stable until completion.
REQ-024 Completion: WR on sampled m_ready=1; RD/POLL on sampled m_rvalid=1, m_rdata captured into last_rdata; then CHECK with m_valid=0 (>=1 idle bus cycle between accesses).
REQ-025 Bus timer cleared on ACCESS entry; reaching BUS_TMO cycles without completion -> err, err_code=1, err_idx=pc, FIN.
REQ-026 CHECK: WR/RD or satisfied POLL -> pc+1 then FETCH; unsatisfied POLL with poll_cnt < POLL_MAX-1 -> poll_cnt+1, ACCESS; else err_code=2, FIN.
REQ-027 poll_cnt cleared on every FETCH.
REQ-028 pc wrap: command at CMD_DEPTH-1 completing in CHECK -> FIN with done=1 (implicit END, no wrap to 0).
REQ-029 abort in any non-IDLE state: m_valid=0 next cycle, err=1, err_code=3, err_idx=pc, FIN; abort in IDLE has no effect.
REQ-030 abort and start in the same cycle in IDLE: start honoured; abort in the same cycle as a completion: abort wins, access counted as not done.
REQ-031 done and err never both high.

Reset
REQ-032 On rst: state=IDLE, pc=0, m_valid/m_write=0, m_addr/m_wdata=0, m_wstrb=0, busy/done/err=0, err_code=0, err_idx=0, last_rdata=0, counters=0.
REQ-033 Command table is not reset; software loads it before start.
REQ-034 rst mid-access drops m_valid asynchronously.

Structure
REQ-035 seq_cmd_t, op encodings and err_code values live in snn_soc_pkg.
REQ-036 Command table as sub-module seq_cmd_ram (1 write port, 1 registered read port); everything else in bus_seq_master.

Verification
REQ-037 Table {WR 0x..04=10, WR 0x..00=10200, END}, slave ready after 2 cycles -> two writes in order, wstrb=F, done=1, err=0.
REQ-038 POLL1 mask 0x2, slave returns 0 three times then 0x2 -> exactly 4 reads, pc advances, last_rdata=0x2, done=1.
REQ-039 POLL0 mask 0x80 with POLL_MAX=8, slave always 0x80 -> 8 reads, err=1, err_code=2, err_idx=poll entry.
REQ-040 Slave never asserts m_ready, BUS_TMO=64 -> m_valid high 64 cycles then low, err_code=1.
REQ-041 abort during POLL access -> m_valid low next cycle, err_code=3; later start re-runs from entry 0 and clears err.
REQ-042 CMD_DEPTH=4 table of WR,WR,WR,WR without END -> 4 writes, done=1, no fifth access.
